// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, mode bit positions and default sizes for spi_master_burst
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        SHIFT,
        HOLD
    } state_t;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    localparam int DEF_WORD_W  = 16;
    localparam int DEF_N_CS    = 8;
    localparam int DEF_DIV_W   = 8;
    localparam int DEF_BURST_W = 4;

    function automatic int cs_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_burst_if.sv
// spi_master_burst_if: control, per-word handshake and SPI pin bundle for spi_master_burst
interface spi_master_burst_if import spi_pkg::*; #(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int N_CS    = DEF_N_CS,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int BURST_W = DEF_BURST_W
);
    localparam int CS_W = cs_width(N_CS);

    logic               start;
    logic [CS_W-1:0]    cs_sel;
    logic [1:0]         mode;
    logic [DIV_W-1:0]   clk_div;
    logic [BURST_W-1:0] burst_len;
    logic [WORD_W-1:0]  tx_word;
    logic               tx_valid;
    logic               tx_ready;
    logic [WORD_W-1:0]  rx_word;
    logic               rx_valid;
    logic               busy;
    logic               done;
    logic               sclk;
    logic               mosi;
    logic               miso;
    logic [N_CS-1:0]    cs_n;

    modport master (
        input  start, cs_sel, mode, clk_div, burst_len, tx_word, tx_valid, miso,
        output tx_ready, rx_word, rx_valid, busy, done, sclk, mosi, cs_n
    );

    modport slave (
        output start, cs_sel, mode, clk_div, burst_len, tx_word, tx_valid, miso,
        input  tx_ready, rx_word, rx_valid, busy, done, sclk, mosi, cs_n
    );

endinterface

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period timer producing leading/trailing SCLK edge strobes while enabled
module spi_clkgen import spi_pkg::*; #(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             half,
    output logic             lead,
    output logic             trail
);
    logic [DIV_W-1:0] cnt;
    logic             ph;

    assign half  = en && (cnt == div - DIV_W'(1));
    assign lead  = half && !ph;
    assign trail = half && ph;

    // count clk cycles within a half-period; ph tells leading from trailing half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else begin
            cnt <= half ? '0 : cnt + DIV_W'(1);
            ph  <= half ? ~ph : ph;
        end
    end

endmodule

// File: rtl/spi_master_burst.sv
// spi_master_burst: burst SPI master, 4 modes, runtime divider; SPI_MASTER_BURST_LOOPBACK_EN samples mosi instead of miso
module spi_master_burst import spi_pkg::*; #(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int N_CS    = DEF_N_CS,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_burst_if.master bus
);
    localparam int BC_W = $clog2(WORD_W);

    state_t             state;
    logic [1:0]         mode_q;
    logic [DIV_W-1:0]   div_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] word_cnt;
    logic [BC_W-1:0]    bit_cnt;
    logic [WORD_W-1:0]  tx_sh;
    logic [WORD_W-1:0]  rx_sh;
    logic [WORD_W-1:0]  rx_word_q;
    logic [N_CS-1:0]    cs_n_q;
    logic               tx_ready_q;
    logic               rx_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               sclk_q;
    logic               mosi_q;
    logic               half;
    logic               lead;
    logic               trail;
    logic               miso_s;
    logic               cpol;
    logic               cpha;
    logic               last_bit;
    logic               last_word;
    logic               go;
    logic [WORD_W-1:0]  rx_next;

    assign cpol      = mode_q[CPOL_BIT];
    assign cpha      = mode_q[CPHA_BIT];
    assign last_bit  = bit_cnt == BC_W'(WORD_W - 1);
    assign last_word = word_cnt == len_q;
    assign go        = bus.start && (int'(bus.cs_sel) < N_CS);
    assign rx_next   = {rx_sh[WORD_W-2:0], miso_s};

`ifdef SPI_MASTER_BURST_LOOPBACK_EN
    assign miso_s = mosi_q;
`else
    assign miso_s = bus.miso;
`endif

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk   (clk),
        .rst   (rst),
        .en    (state == SETUP || state == SHIFT || state == HOLD),
        .div   (div_q),
        .half  (half),
        .lead  (lead),
        .trail (trail)
    );

    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_word  = rx_word_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_n_q;

    // transfer sequencer: chip select, word handshake, bit shifting and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= '0;
            div_q      <= DIV_W'(1);
            len_q      <= '0;
            word_cnt   <= '0;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_word_q  <= '0;
            cs_n_q     <= '1;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    mode_q   <= bus.mode;
                    div_q    <= (bus.clk_div == '0) ? DIV_W'(1) : bus.clk_div;
                    len_q    <= bus.burst_len;
                    word_cnt <= '0;
                    cs_n_q   <= ~(N_CS'(1) << bus.cs_sel);
                    busy_q   <= 1'b1;
                    sclk_q   <= bus.mode[CPOL_BIT];
                    state    <= SETUP;
                end
                SETUP: if (half) begin
                    tx_ready_q <= 1'b1;
                    state      <= LOAD;
                end
                LOAD: if (bus.tx_valid) begin
                    tx_ready_q <= 1'b0;
                    tx_sh      <= bus.tx_word;
                    bit_cnt    <= '0;
                    mosi_q     <= cpha ? mosi_q : bus.tx_word[WORD_W-1];
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (lead) begin
                        sclk_q <= ~cpol;
                        mosi_q <= cpha ? tx_sh[WORD_W-1] : mosi_q;
                        tx_sh  <= cpha ? tx_sh << 1 : tx_sh;
                        rx_sh  <= cpha ? rx_sh : rx_next;
                    end
                    if (trail) begin
                        sclk_q  <= cpol;
                        bit_cnt <= bit_cnt + BC_W'(1);
                        rx_sh   <= cpha ? rx_next : rx_sh;
                        mosi_q  <= (cpha || last_bit) ? mosi_q : tx_sh[WORD_W-2];
                        tx_sh   <= (cpha || last_bit) ? tx_sh : tx_sh << 1;
                        if (last_bit) begin
                            rx_valid_q <= 1'b1;
                            rx_word_q  <= cpha ? rx_next : rx_sh;
                            tx_ready_q <= !last_word;
                            word_cnt   <= last_word ? word_cnt : word_cnt + BURST_W'(1);
                            state      <= last_word ? HOLD : LOAD;
                        end
                    end
                end
                HOLD: if (half) begin
                    cs_n_q <= '1;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
